// File: rtl/aes_pkg.sv
// Shared AES constants and controller state encoding.
package aes_pkg;

  localparam int unsigned AES_NR   = 10;
  localparam int unsigned BLK_W    = 128;
  localparam int unsigned RK_IDX_W = 4;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round controller: initial AddRoundKey on accept, then
// sequences an external single-round datapath through rounds 1..NR.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR        = AES_NR,
  parameter int unsigned ROUND_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BLK_W-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BLK_W-1:0]    out_data,
  input  logic                flush,
  output logic                busy,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [BLK_W-1:0]    rk_in,
  output logic [BLK_W-1:0]    dp_data,
  output logic                dp_final,
  output logic                dp_start,
  input  logic [BLK_W-1:0]    dp_result
);

  localparam logic [RK_IDX_W-1:0] NR_L     = RK_IDX_W'(NR);
  localparam logic [CNT_W-1:0]    LAT_LAST = CNT_W'(ROUND_LAT - 1);

  state_e                st_q, st_d;
  logic [RK_IDX_W-1:0]   round_q, round_d;
  logic [CNT_W-1:0]      lat_q, lat_d;
  logic [BLK_W-1:0]      data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      round_q <= '0;
      lat_q   <= '0;
      data_q  <= '0;
    end else begin
      st_q    <= st_d;
      round_q <= round_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
    end
  end

  // Outputs are decoded from state/round/lat_cnt only; no input feeds an output directly.
  always_comb begin
    st_d      = st_q;
    round_d   = round_q;
    lat_d     = lat_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    rk_idx    = '0;
    dp_final  = 1'b0;
    dp_start  = 1'b0;

    case (st_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          data_d  = in_data ^ rk_in;
          round_d = RK_IDX_W'(1);
          lat_d   = '0;
          st_d    = ROUND;
        end
      end
      ROUND: begin
        rk_idx   = round_q;
        dp_final = (round_q == NR_L);
        dp_start = (lat_q == '0);
        if (lat_q == LAT_LAST) begin
          data_d = dp_result;
          lat_d  = '0;
          if (round_q == NR_L) begin
            st_d = DONE;
          end else begin
            round_d = round_q + RK_IDX_W'(1);
          end
        end else begin
          lat_d = lat_q + CNT_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        rk_idx    = NR_L;
        if (out_ready) begin
          st_d    = IDLE;
          round_d = '0;
        end
      end
      default: begin
        st_d = IDLE;
        busy = 1'b0;
      end
    endcase

    // Abort wins over any transition; the state register keeps its contents.
    if (flush) begin
      st_d    = IDLE;
      round_d = '0;
      lat_d   = '0;
      data_d  = data_q;
    end
  end

  assign out_data = data_q;
  assign dp_data  = data_q;

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption round controller. Accepts one plaintext block over a valid/ready handshake and performs the initial AddRoundKey on the input. It then sequences a shared single-round datapath through rounds 1..NR, selecting the final-round variant on round NR, and presents the ciphertext over a second valid/ready handshake. It sits between the block-level stream interface and the round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey) plus the precomputed round-key table.

## Interface
- NR, default 10: number of rounds (10 for AES-128); rk_idx must cover 0..NR.
- ROUND_LAT, default 1: datapath cycles from dp_start to dp_result being valid; legal range 1..15.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  plaintext present
- in_ready  output  1  controller can accept a block
- in_data  input  128  plaintext block
- out_valid  output  1  ciphertext present
- out_ready  input  1  consumer accepts ciphertext
- out_data  output  128  ciphertext (state register)
- flush  input  1  synchronous abort of the current block
- busy  output  1  high in any state but IDLE
- rk_idx  output  4  round-key table index
- rk_in  input  128  round key for rk_idx, combinational, same cycle
- dp_data  output  128  state fed to round datapath
- dp_final  output  1  select final round (no MixColumns)
- dp_start  output  1  one-cycle pulse on first cycle of each round
- dp_result  input  128  datapath output, valid ROUND_LAT cycles after dp_start

## Operation
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, rk_idx=0.
  - On in_valid: state ← in_data ^ rk_in, round ← 1, lat_cnt ← 0, go to ROUND.
- ROUND:
  - rk_idx=round, dp_data=state, dp_final=(round==NR).
  - dp_start=1 when lat_cnt==0.
  - lat_cnt increments each cycle. When lat_cnt==ROUND_LAT-1:
    - state ← dp_result, lat_cnt ← 0.
    - If round==NR, go to DONE; else round ← round+1.
- DONE:
  - out_valid=1, out_data=state, rk_idx=NR.
  - On out_ready, go to IDLE.
  - state holds unchanged while out_ready=0.
- Only one block is in flight. in_ready=0 outside IDLE; in_valid is ignored there.
- No accept in the same cycle as the DONE→IDLE transition; the next accept is at the earliest one cycle later.
- flush has priority over every transition:
  - Next state is IDLE; round, lat_cnt and the outputs return to reset values.
  - state is left unchanged.
  - A flush while in IDLE with in_valid=1 does not accept the block.
- round is 4 bits and never wraps past NR. lat_cnt is 4 bits.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - dp_start=0, dp_final=0, rk_idx=0, round=0, lat_cnt=0, state register=0.
  - out_data=0, dp_data=0.
- Accept edge E0 means in_valid&&in_ready are sampled high.
  - dp_start for round r is high during cycle E0+(r-1)·ROUND_LAT.
  - out_valid rises after edge E0+NR·ROUND_LAT.
  - Default parameters: ciphertext is valid 10 cycles after accept.
- Throughput: one block per NR·ROUND_LAT+2 cycles when out_ready is held high.
- Asserting rst_n low mid-operation forces the reset values immediately, without waiting for a clock edge. The in-flight block is lost.
- All outputs are driven from registers or decoded from state/round only. There is no combinational path from in_valid or out_ready to any output except through a registered transition.

## Structure
- Shared package aes_pkg holds:
  - the AES_NR constant (10);
  - the block width constant (128);
  - the state enum {IDLE, ROUND, DONE}.
- Single module; the latency counter and round counter are inline. No sub-module is warranted.
- The datapath and the key table are instantiated by the parent, not inside this block.

## Test plan
- FIPS-197 C.1 vector with a golden round-datapath model and key table:
  - stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff;
  - required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid rising exactly 10 cycles after accept;
  - required: dp_final high only in round 10.
- ROUND_LAT=3, same vector:
  - required: out_valid at cycle 30 after accept;
  - required: dp_start pulses at offsets 0,3,…,27;
  - required: rk_idx steps 1..10 every 3 cycles.
- Backpressure: hold out_ready=0 for 7 cycles in DONE.
  - Required: out_data stable, in_ready=0, busy=1.
  - Required: return to IDLE on the first out_ready=1 edge.
- in_valid held high for the whole run:
  - required: exactly one block accepted per transaction;
  - required: back-to-back blocks are spaced 12 cycles apart with out_ready=1.
- Assert flush in round 5:
  - required: next cycle shows IDLE, in_ready=1, out_valid=0;
  - required: a following block encrypts correctly.
- Pull rst_n low mid-ROUND, between clock edges:
  - required: outputs reach their reset values before the next edge;
  - required: normal operation after release.
